// File: rtl/pixel_pack_dbuf_pkg.sv
// Shared types and size helpers for the 1-bpp edge-stream packer and its bank controller.
package pixel_pack_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_SOF = 3'd0,
    ST_PACK     = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_DONE     = 3'd3,
    ST_DROP     = 3'd4
  } pp_state_t;

  function automatic int pp_words(input int frame_pixels, input int word_w);
    return (frame_pixels + word_w - 1) / word_w;
  endfunction

  // A one-word frame still needs a 1-bit index so the address concatenation stays legal.
  function automatic int pp_widx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/pixel_pack_dbuf_if.sv
// Pixel-in / RAM-write-out bundle of the packer; slave is the packer side, master the driver side.
interface pixel_pack_dbuf_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 14
) ();

  logic              vsync;
  logic              pix_de;
  logic [7:0]        pix_data;
  logic              rd_release;
  logic              rd_bank;
  logic              we;
  logic [WORD_W-1:0] wData;
  logic [ADDR_W-1:0] wAddr;
  logic              frame_tick;
  logic              frame_bank;
  logic              frame_drop;
  logic              frame_short;

  modport slave (
    input  vsync, pix_de, pix_data, rd_release, rd_bank,
    output we, wData, wAddr, frame_tick, frame_bank, frame_drop, frame_short
  );

  modport master (
    output vsync, pix_de, pix_data, rd_release, rd_bank,
    input  we, wData, wAddr, frame_tick, frame_bank, frame_drop, frame_short
  );

endinterface

// File: rtl/pixel_pack_dbuf_bank_ctrl.sv
// Tracks which frame-buffer banks hold unread frames and offers the lowest free bank to the packer.
module pixel_bank_ctrl #(
  parameter int DOUBLE_BUF = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic claim,
  input  logic claim_bank,
  input  logic complete,
  input  logic rel_valid,
  input  logic rel_bank,
  output logic free_valid,
  output logic free_bank
);

  logic [1:0] full_q, full_d;
  logic       active_q, active_d;
  logic       active_bank_q, active_bank_d;
  logic [1:0] full_rel;

  // Release is applied before free-bank selection so a same-cycle vsync can reuse the bank.
  always_comb begin
    full_rel      = full_q;
    full_d        = full_q;
    active_d      = active_q;
    active_bank_d = active_bank_q;
    free_valid    = 1'b0;
    free_bank     = 1'b0;

    if (rel_valid && !(active_q && (rel_bank == active_bank_q))) begin
      full_rel[rel_bank] = 1'b0;
    end else begin
      full_rel = full_q;
    end

    full_d = full_rel;
    if (complete) begin
      full_d[active_bank_q] = 1'b1;
      active_d              = 1'b0;
    end else if (claim) begin
      active_d      = 1'b1;
      active_bank_d = claim_bank;
    end else begin
      active_d = active_q;
    end

    if (!full_rel[0]) begin
      free_valid = 1'b1;
      free_bank  = 1'b0;
    end else if ((DOUBLE_BUF != 0) && !full_rel[1]) begin
      free_valid = 1'b1;
      free_bank  = 1'b1;
    end else begin
      free_valid = 1'b0;
      free_bank  = 1'b0;
    end
  end

  // Bank occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q        <= 2'b00;
      active_q      <= 1'b0;
      active_bank_q <= 1'b0;
    end else begin
      full_q        <= full_d;
      active_q      <= active_d;
      active_bank_q <= active_bank_d;
    end
  end

endmodule

// File: rtl/pixel_pack_dbuf.sv
// Packs a thresholded 1-bpp pixel stream into WORD_W-bit words and writes them into a
// (optionally ping-pong) frame buffer, with vsync resync and zero-padded flush of the last word.
module pixel_pack_dbuf
  import pixel_pack_pkg::*;
#(
  parameter int WORD_W       = 8,
  parameter int FRAME_PIXELS = 40800,
  parameter int THRESH       = 1,
  parameter int MSB_FIRST    = 0,
  parameter int DOUBLE_BUF   = 1
) (
  input logic              clk,
  input logic              reset,
  pixel_pack_dbuf_if.slave bus
);

  localparam int WORDS  = pp_words(FRAME_PIXELS, WORD_W);
  localparam int WIDX_W = pp_widx_w(WORDS);
  localparam int ADDR_W = WIDX_W + 1;
  localparam int PC_W   = $clog2(FRAME_PIXELS + 1);
  localparam int BC_W   = $clog2(WORD_W);

  pp_state_t         state_q, state_d;
  logic              bank_q, bank_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PC_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;

  logic              we_q, we_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              frame_tick_q, frame_tick_d;
  logic              frame_bank_q, frame_bank_d;
  logic              frame_drop_q, frame_drop_d;
  logic              frame_short_q, frame_short_d;

  logic              claim, complete, free_valid, free_bank;
  logic              pix_bit, word_full, last_pix;
  logic [BC_W-1:0]   bit_pos;
  logic [WORD_W-1:0] acc_ins;

  pixel_bank_ctrl #(.DOUBLE_BUF(DOUBLE_BUF)) u_bank_ctrl (
    .clk        (clk),
    .reset      (reset),
    .claim      (claim),
    .claim_bank (bank_d),
    .complete   (complete),
    .rel_valid  (bus.rd_release),
    .rel_bank   (bus.rd_bank),
    .free_valid (free_valid),
    .free_bank  (free_bank)
  );

  // Accumulator insert position and end-of-word / end-of-frame detection.
  always_comb begin
    pix_bit   = (bus.pix_data >= 8'(THRESH));
    bit_pos   = (MSB_FIRST != 0) ? (BC_W'(WORD_W - 1) - bit_cnt_q) : bit_cnt_q;
    acc_ins   = pix_bit ? (acc_q | ({{(WORD_W-1){1'b0}}, 1'b1} << bit_pos)) : acc_q;
    word_full = (bit_cnt_q == BC_W'(WORD_W - 1));
    last_pix  = (pix_cnt_q == PC_W'(FRAME_PIXELS - 1));
  end

  // Frame FSM: next state, counters and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    acc_d         = acc_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    word_idx_d    = word_idx_q;
    we_d          = 1'b0;
    wdata_d       = wdata_q;
    waddr_d       = waddr_q;
    frame_tick_d  = 1'b0;
    frame_bank_d  = frame_bank_q;
    frame_drop_d  = 1'b0;
    frame_short_d = 1'b0;
    claim         = 1'b0;
    complete      = 1'b0;

    case (state_q)
      ST_WAIT_SOF, ST_DROP: begin
        if (bus.vsync && free_valid) begin
          claim      = 1'b1;
          bank_d     = free_bank;
          acc_d      = {WORD_W{1'b0}};
          bit_cnt_d  = {BC_W{1'b0}};
          pix_cnt_d  = {PC_W{1'b0}};
          word_idx_d = {WIDX_W{1'b0}};
          state_d    = ST_PACK;
        end else if (bus.vsync) begin
          frame_drop_d = 1'b1;
          state_d      = ST_DROP;
        end else begin
          state_d = state_q;
        end
      end

      ST_PACK: begin
        if (bus.vsync) begin
          frame_short_d = 1'b1;
          acc_d         = {WORD_W{1'b0}};
          bit_cnt_d     = {BC_W{1'b0}};
          pix_cnt_d     = {PC_W{1'b0}};
          word_idx_d    = {WIDX_W{1'b0}};
          state_d       = ST_PACK;
        end else if (bus.pix_de) begin
          pix_cnt_d = pix_cnt_q + PC_W'(1);
          if (word_full) begin
            we_d      = 1'b1;
            wdata_d   = acc_ins;
            waddr_d   = {bank_q, word_idx_q};
            acc_d     = {WORD_W{1'b0}};
            bit_cnt_d = {BC_W{1'b0}};
            if (last_pix) begin
              state_d = ST_DONE;
            end else begin
              word_idx_d = word_idx_q + WIDX_W'(1);
            end
          end else begin
            acc_d     = acc_ins;
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            if (last_pix) begin
              state_d = ST_FLUSH;
            end else begin
              state_d = ST_PACK;
            end
          end
        end else begin
          state_d = ST_PACK;
        end
      end

      ST_FLUSH: begin
        if (bus.vsync) begin
          frame_short_d = 1'b1;
          acc_d         = {WORD_W{1'b0}};
          bit_cnt_d     = {BC_W{1'b0}};
          pix_cnt_d     = {PC_W{1'b0}};
          word_idx_d    = {WIDX_W{1'b0}};
          state_d       = ST_PACK;
        end else begin
          // Unfilled accumulator bits are already zero, which gives the required padding.
          we_d      = 1'b1;
          wdata_d   = acc_q;
          waddr_d   = {bank_q, WIDX_W'(WORDS - 1)};
          acc_d     = {WORD_W{1'b0}};
          bit_cnt_d = {BC_W{1'b0}};
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        frame_tick_d = 1'b1;
        frame_bank_d = bank_q;
        complete     = 1'b1;
        state_d      = ST_WAIT_SOF;
      end

      default: begin
        state_d = ST_WAIT_SOF;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WAIT_SOF;
      bank_q        <= 1'b0;
      acc_q         <= {WORD_W{1'b0}};
      bit_cnt_q     <= {BC_W{1'b0}};
      pix_cnt_q     <= {PC_W{1'b0}};
      word_idx_q    <= {WIDX_W{1'b0}};
      we_q          <= 1'b0;
      wdata_q       <= {WORD_W{1'b0}};
      waddr_q       <= {ADDR_W{1'b0}};
      frame_tick_q  <= 1'b0;
      frame_bank_q  <= 1'b0;
      frame_drop_q  <= 1'b0;
      frame_short_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      acc_q         <= acc_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      word_idx_q    <= word_idx_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      waddr_q       <= waddr_d;
      frame_tick_q  <= frame_tick_d;
      frame_bank_q  <= frame_bank_d;
      frame_drop_q  <= frame_drop_d;
      frame_short_q <= frame_short_d;
    end
  end

  assign bus.we          = we_q;
  assign bus.wData       = wdata_q;
  assign bus.wAddr       = waddr_q;
  assign bus.frame_tick  = frame_tick_q;
  assign bus.frame_bank  = frame_bank_q;
  assign bus.frame_drop  = frame_drop_q;
  assign bus.frame_short = frame_short_q;

endmodule

// File: tb/tb_pixel_pack_dbuf.sv
// Self-checking bench: LSB-first and MSB-first packers share stimulus; a frame-level model predicts outputs.
module tb_pixel_pack_dbuf;

  localparam int W     = 8;
  localparam int FP    = 20;
  localparam int WORDS = 3;
  localparam int AW    = 3;

  localparam int M_WAIT  = 0;
  localparam int M_PACK  = 1;
  localparam int M_FLUSH = 2;
  localparam int M_DONE  = 3;
  localparam int M_DROP  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_pack_dbuf_if #(.WORD_W(W), .ADDR_W(AW)) bus0 ();
  pixel_pack_dbuf_if #(.WORD_W(W), .ADDR_W(AW)) bus1 ();

  pixel_pack_dbuf #(.WORD_W(W), .FRAME_PIXELS(FP), .THRESH(1), .MSB_FIRST(0), .DOUBLE_BUF(1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  pixel_pack_dbuf #(.WORD_W(W), .FRAME_PIXELS(FP), .THRESH(1), .MSB_FIRST(1), .DOUBLE_BUF(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_pass   = 0;

  int       m_mode = M_WAIT;
  bit       m_bank = 1'b0;
  bit [1:0] m_full = 2'b00;
  bit       m_bits[$];
  bit       e_we, e_tick, e_fbank, e_drop, e_short, e_data_cmp;
  logic [7:0]  e_wd0, e_wd1;
  logic [AW-1:0] e_wa;
  logic [7:0]  log0[$];
  logic [7:0]  log1[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mword(input int idx, input bit msb);
    logic [7:0] r;
    r = 8'd0;
    for (int j = 0; j < W; j++) begin
      int p;
      p = idx * W + j;
      if (p < m_bits.size() && m_bits[p]) r[msb ? (W - 1 - j) : j] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_start();
    m_bits.delete();
    if (!m_full[0]) begin
      m_bank = 1'b0; m_mode = M_PACK;
    end else if (!m_full[1]) begin
      m_bank = 1'b1; m_mode = M_PACK;
    end else begin
      e_drop = 1'b1; m_mode = M_DROP;
    end
  endtask

  task automatic model_step(input bit vs, input bit de, input logic [7:0] d,
                            input bit rel, input bit rb, input bit rst);
    bit active;
    int n;
    e_we = 1'b0; e_tick = 1'b0; e_drop = 1'b0; e_short = 1'b0; e_data_cmp = 1'b0;
    if (rst) begin
      m_mode = M_WAIT; m_full = 2'b00; m_bank = 1'b0; m_bits.delete();
      e_fbank = 1'b0; e_wd0 = 8'd0; e_wd1 = 8'd0; e_wa = '0; e_data_cmp = 1'b1;
      return;
    end
    active = (m_mode == M_PACK) || (m_mode == M_FLUSH) || (m_mode == M_DONE);
    if (rel && !(active && rb == m_bank)) m_full[rb] = 1'b0;
    case (m_mode)
      M_WAIT, M_DROP: if (vs) model_start();
      M_PACK: begin
        if (vs) begin
          e_short = 1'b1; m_bits.delete();
        end else if (de) begin
          m_bits.push_back(d >= 8'd1);
          n = m_bits.size();
          if (n % W == 0) begin
            e_we = 1'b1; e_data_cmp = 1'b1;
            e_wa = {m_bank, 2'(n / W - 1)};
            e_wd0 = mword(n / W - 1, 1'b0);
            e_wd1 = mword(n / W - 1, 1'b1);
          end
          if (n == FP) m_mode = (n % W == 0) ? M_DONE : M_FLUSH;
        end
      end
      M_FLUSH: begin
        if (vs) begin
          e_short = 1'b1; m_bits.delete(); m_mode = M_PACK;
        end else begin
          e_we = 1'b1; e_data_cmp = 1'b1;
          e_wa = {m_bank, 2'(WORDS - 1)};
          e_wd0 = mword(WORDS - 1, 1'b0);
          e_wd1 = mword(WORDS - 1, 1'b1);
          m_mode = M_DONE;
        end
      end
      M_DONE: begin
        e_tick = 1'b1; e_fbank = m_bank; m_full[m_bank] = 1'b1; m_mode = M_WAIT;
      end
      default: m_mode = M_WAIT;
    endcase
  endtask

  task automatic cyc(input bit vs, input bit de, input logic [7:0] d,
                     input bit rel, input bit rb, input bit rst);
    @(negedge clk);
    reset = rst;
    bus0.vsync = vs; bus0.pix_de = de; bus0.pix_data = d; bus0.rd_release = rel; bus0.rd_bank = rb;
    bus1.vsync = vs; bus1.pix_de = de; bus1.pix_data = d; bus1.rd_release = rel; bus1.rd_bank = rb;
    @(posedge clk);
    model_step(vs, de, d, rel, rb, rst);
    #1;
    check_eq("we0", 32'(bus0.we), 32'(e_we));
    check_eq("we1", 32'(bus1.we), 32'(e_we));
    check_eq("frame_tick", 32'(bus0.frame_tick), 32'(e_tick));
    check_eq("frame_bank", 32'(bus0.frame_bank), 32'(e_fbank));
    check_eq("frame_drop", 32'(bus0.frame_drop), 32'(e_drop));
    check_eq("frame_short", 32'(bus0.frame_short), 32'(e_short));
    if (e_data_cmp) begin
      check_eq("wData_lsb", 32'(bus0.wData), 32'(e_wd0));
      check_eq("wData_msb", 32'(bus1.wData), 32'(e_wd1));
      check_eq("wAddr", 32'(bus0.wAddr), 32'(e_wa));
    end
    if (bus0.we === 1'b1) log0.push_back(bus0.wData);
    if (bus1.we === 1'b1) log1.push_back(bus1.wData);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alt_frame(input int npix);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < npix; i++) cyc(1'b0, 1'b1, (i % 2 == 1) ? 8'd255 : 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] rdata();
    case ($urandom_range(0, 3))
      0:       return 8'd0;
      1:       return 8'd1;
      2:       return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [7:0] exp_lsb[3];
    logic [7:0] exp_msb[3];
    exp_lsb[0] = 8'hAA; exp_lsb[1] = 8'hAA; exp_lsb[2] = 8'h0A;
    exp_msb[0] = 8'h55; exp_msb[1] = 8'h55; exp_msb[2] = 8'h50;

    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);

    // Alternating-bit frame; also checked against literal words.
    log0.delete(); log1.delete();
    alt_frame(FP); idle(3);
    check_eq("alt_words_lsb_n", 32'(log0.size()), 32'd3);
    check_eq("alt_words_msb_n", 32'(log1.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq("alt_word_lsb", (i < log0.size()) ? 32'(log0[i]) : 32'hDEAD, 32'(exp_lsb[i]));
      check_eq("alt_word_msb", (i < log1.size()) ? 32'(log1[i]) : 32'hDEAD, 32'(exp_msb[i]));
    end

    // Bank 1, then drop, then release bank 0 and refill it.
    alt_frame(FP); idle(3);
    log0.delete();
    alt_frame(FP); idle(2);
    check_eq("drop_no_we", 32'(log0.size()), 32'd0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    alt_frame(FP); idle(3);

    // Short frame after 11 pixels, then a full frame in the same bank.
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    alt_frame(11); alt_frame(FP); idle(3);

    // Reset in the middle of a frame.
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    alt_frame(12);
    cyc(1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b1);
    idle(1);
    alt_frame(FP); idle(3);

    // Randomised frames, gaps, releases, early vsyncs and occasional resets.
    for (int f = 0; f < 60; f++) begin
      int len;
      bit vs, de, rel, rb;
      len = $urandom_range(10, 40);
      de = ($urandom_range(0, 1) == 1);
      cyc(1'b1, de, rdata(), 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < len; k++) begin
        vs  = ($urandom_range(0, 39) == 0);
        de  = ($urandom_range(0, 3) != 0);
        rel = ($urandom_range(0, 7) == 0);
        rb  = ($urandom_range(0, 1) == 1);
        cyc(vs, de, rdata(), rel, rb, 1'b0);
      end
      for (int k = 0; k < $urandom_range(0, 3); k++) begin
        rel = ($urandom_range(0, 2) == 0);
        rb  = ($urandom_range(0, 1) == 1);
        cyc(1'b0, 1'b0, 8'd0, rel, rb, 1'b0);
      end
      if ($urandom_range(0, 19) == 0) cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
